// File: rtl/shift_reg_bank.sv
// WIDTH x DEPTH register bank with hold / shift up / shift down / parallel load and fill tracking.
// Optional rotate on shift, enabled by defining USR_ROTATE_EN.
module shift_reg_bank #(
  parameter int unsigned     WIDTH     = 4,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic [1:0]               mode_i,
  input  logic                     rot_i,
  input  logic [WIDTH-1:0]         d_i,
  input  logic [WIDTH*DEPTH-1:0]   par_i,
  output logic [WIDTH*DEPTH-1:0]   q_o,
  output logic [WIDTH*DEPTH-1:0]   notq_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         tail_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                     full_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [CW-1:0]               cnt_inc;
  logic                        rotate;

`ifdef USR_ROTATE_EN
  assign rotate = rot_i;
`else
  logic unused_rot;
  assign unused_rot = rot_i;
  assign rotate     = 1'b0;
`endif

  // Fill count saturates at DEPTH
  assign cnt_inc = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);

  // Next-state selection: clear beats mode; rotate leaves the fill count alone
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      stage_d = {DEPTH{RESET_VAL}};
      cnt_d   = '0;
    end else begin
      case (mode_i)
        MODE_HOLD: ;
        MODE_UP: begin
          if (rotate) begin
            stage_d = {stage_q[DEPTH-2:0], stage_q[DEPTH-1]};
          end else begin
            stage_d = {stage_q[DEPTH-2:0], d_i};
            cnt_d   = cnt_inc;
          end
        end
        MODE_DOWN: begin
          if (rotate) begin
            stage_d = {stage_q[0], stage_q[DEPTH-1:1]};
          end else begin
            stage_d = {d_i, stage_q[DEPTH-1:1]};
            cnt_d   = cnt_inc;
          end
        end
        MODE_LOAD: begin
          stage_d = par_i;
          cnt_d   = CW'(DEPTH);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= {DEPTH{RESET_VAL}};
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o    = stage_q;
  assign notq_o = ~stage_q;
  assign head_o = stage_q[DEPTH-1];
  assign tail_o = stage_q[0];
  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == CW'(DEPTH));

endmodule

// File: tb/tb_shift_reg_bank.sv
// Directed bench for shift_reg_bank at WIDTH=4, DEPTH=4, RESET_VAL=0.
// Expected rotate result follows USR_ROTATE_EN when defined for the build.
module tb_shift_reg_bank;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D+1);

  logic              clk = 1'b0;
  logic              rst_i;
  logic              clr_i;
  logic [1:0]        mode_i;
  logic              rot_i;
  logic [W-1:0]      d_i;
  logic [W*D-1:0]    par_i;
  logic [W*D-1:0]    q_o;
  logic [W*D-1:0]    notq_o;
  logic [W-1:0]      head_o;
  logic [W-1:0]      tail_o;
  logic [CW-1:0]     cnt_o;
  logic              full_o;

  int checks = 0;
  int passed = 0;

  shift_reg_bank #(.WIDTH(W), .DEPTH(D), .RESET_VAL(4'h0)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .clr_i  (clr_i),
    .mode_i (mode_i),
    .rot_i  (rot_i),
    .d_i    (d_i),
    .par_i  (par_i),
    .q_o    (q_o),
    .notq_o (notq_o),
    .head_o (head_o),
    .tail_o (tail_o),
    .cnt_o  (cnt_o),
    .full_o (full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive on the falling edge, then settle just after the next rising edge
  task automatic step(input logic [1:0] m, input logic [W-1:0] d, input logic [W*D-1:0] p,
                      input logic c, input logic r);
    @(negedge clk);
    mode_i = m; d_i = d; par_i = p; clr_i = c; rot_i = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; clr_i = 1'b0; mode_i = 2'b00; rot_i = 1'b0; d_i = '0; par_i = '0;

    // Asynchronous reset seen before any edge
    #3 rst_i = 1'b1;
    #1;
    check("rst_q",    32'(q_o),    32'h0000);
    check("rst_notq", 32'(notq_o), 32'hFFFF);
    check("rst_cnt",  32'(cnt_o),  32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Fill by shifting up
    step(2'b01, 4'h1, '0, 1'b0, 1'b0);
    check("up1_cnt", 32'(cnt_o), 32'd1);
    check("up1_q",   32'(q_o),   32'h0001);
    step(2'b01, 4'h2, '0, 1'b0, 1'b0);
    check("up2_cnt", 32'(cnt_o), 32'd2);
    step(2'b01, 4'h3, '0, 1'b0, 1'b0);
    check("up3_cnt",  32'(cnt_o),  32'd3);
    check("up3_full", 32'(full_o), 32'd0);
    step(2'b01, 4'h4, '0, 1'b0, 1'b0);
    check("up4_q",    32'(q_o),    32'h1234);
    check("up4_notq", 32'(notq_o), 32'hEDCB);
    check("up4_tail", 32'(tail_o), 32'h4);
    check("up4_head", 32'(head_o), 32'h1);
    check("up4_cnt",  32'(cnt_o),  32'd4);
    check("up4_full", 32'(full_o), 32'd1);
    step(2'b01, 4'h5, '0, 1'b0, 1'b0);
    check("up5_q",   32'(q_o),   32'h2345);
    check("up5_cnt", 32'(cnt_o), 32'd4);

    // Parallel load then shift down
    step(2'b11, 4'h0, 16'hABCD, 1'b0, 1'b0);
    check("load_q",   32'(q_o),   32'hABCD);
    check("load_cnt", 32'(cnt_o), 32'd4);
    step(2'b10, 4'hE, 16'h0000, 1'b0, 1'b0);
    check("down_q",    32'(q_o),    32'hEABC);
    check("down_head", 32'(head_o), 32'hE);
    check("down_tail", 32'(tail_o), 32'hC);
    check("down_cnt",  32'(cnt_o),  32'd4);

    // Clear outranks load, then hold
    step(2'b11, 4'h0, 16'hFFFF, 1'b1, 1'b0);
    check("clr_q",    32'(q_o),    32'h0000);
    check("clr_cnt",  32'(cnt_o),  32'd0);
    check("clr_full", 32'(full_o), 32'd0);
    step(2'b00, 4'h9, 16'h5555, 1'b0, 1'b0);
    check("hold0_q",   32'(q_o),   32'h0000);
    check("hold0_cnt", 32'(cnt_o), 32'd0);

    // Shift down from empty fills from the head end
    step(2'b10, 4'h7, '0, 1'b0, 1'b0);
    check("dn_empty_q",   32'(q_o),   32'h7000);
    check("dn_empty_cnt", 32'(cnt_o), 32'd1);

    // Hold keeps a non-zero pattern
    step(2'b11, 4'h0, 16'h1234, 1'b0, 1'b0);
    step(2'b00, 4'h9, 16'h5555, 1'b0, 1'b1);
    check("hold_q", 32'(q_o), 32'h1234);

    // Rotate request on shift up
    step(2'b01, 4'h0, '0, 1'b0, 1'b1);
`ifdef USR_ROTATE_EN
    check("rot_q", 32'(q_o), 32'h2341);
`else
    check("rot_q", 32'(q_o), 32'h2340);
`endif
    check("rot_cnt", 32'(cnt_o), 32'd4);

    // Reset in the middle of streaming
    step(2'b00, 4'h0, '0, 1'b1, 1'b0);
    step(2'b01, 4'h1, '0, 1'b0, 1'b0);
    step(2'b01, 4'h2, '0, 1'b0, 1'b0);
    check("strm_q",   32'(q_o),   32'h0012);
    check("strm_cnt", 32'(cnt_o), 32'd2);
    @(negedge clk);
    rst_i = 1'b1; mode_i = 2'b01; d_i = 4'h3;
    #1;
    check("mid_rst_q",   32'(q_o),   32'h0000);
    check("mid_rst_cnt", 32'(cnt_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("rel_edge_q",   32'(q_o),   32'h0000);
    check("rel_edge_cnt", 32'(cnt_o), 32'd0);
    @(posedge clk);
    #1;
    check("post_rel_tail", 32'(tail_o), 32'h3);
    check("post_rel_q",    32'(q_o),    32'h0003);
    check("post_rel_cnt",  32'(cnt_o),  32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_bank.md
# shift_reg_bank

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit × DEPTH-stage register bank.
- Per-cycle mode control selects hold, shift up, shift down or parallel load.
- Tracks fill level since the last clear; optional rotate feature.
- Sits in the lab datapath as a general delay line, serial-to-parallel or parallel-to-serial stage.

## Interface
- WIDTH, 4: bits per stage; must be ≥1.
- DEPTH, 4: number of stages; must be ≥2.
- RESET_VAL, 0: WIDTH-bit value loaded into every stage on reset and clear.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- clr_i  input  1  synchronous clear.
- mode_i  input  2  operation select: 00 hold, 01 shift up, 10 shift down, 11 parallel load.
- rot_i  input  1  rotate request; used only when USR_ROTATE_EN is defined.
- d_i  input  WIDTH  serial input word.
- par_i  input  WIDTH*DEPTH  parallel load data; stage k occupies bits [k*WIDTH +: WIDTH].
- q_o  output  WIDTH*DEPTH  all stages, same packing as par_i.
- notq_o  output  WIDTH*DEPTH  bitwise complement of q_o.
- head_o  output  WIDTH  stage DEPTH-1.
- tail_o  output  WIDTH  stage 0.
- cnt_o  output  $clog2(DEPTH+1)  number of stages written since the last reset or clear.
- full_o  output  1  high when cnt_o == DEPTH.

## Operation
- rst_i high: all stages = RESET_VAL and cnt_o = 0, immediately with no clock edge.
  - Reset values: q_o = {DEPTH{RESET_VAL}}, notq_o = its complement, full_o = 0.
- Priority at each edge: clr_i first, then mode_i.
- clr_i = 1: stages = RESET_VAL and cnt = 0, regardless of mode_i.
- Mode 00 (hold): no change to stages or cnt.
- Mode 01 (shift up):
  - stage[k] ← stage[k-1] for k ≥ 1.
  - stage[0] ← d_i.
  - cnt ← min(cnt+1, DEPTH).
- Mode 10 (shift down):
  - stage[k] ← stage[k+1] for k ≤ DEPTH-2.
  - stage[DEPTH-1] ← d_i.
  - cnt ← min(cnt+1, DEPTH).
- Mode 11 (parallel load): stages ← par_i; cnt ← DEPTH.
- cnt saturates at DEPTH and never wraps.
- Shifting into a full bank discards the word leaving the far end; there is no error flag.

## Timing
- Stages and cnt are registered; head_o, tail_o, notq_o and full_o are combinational from them.
- Latency, shift up: d_i sampled at edge n appears on tail_o after edge n and on head_o after edge n+DEPTH-1.
- Latency, shift down: the same path with head_o and tail_o swapped.
- Parallel load: visible on q_o one edge after sampling.
- Reset asserted mid-shift overrides any in-flight update.
- Reset release on the same edge as mode 01: that edge is ignored; the first shift occurs on the following edge.
- No handshake: every edge with mode_i ≠ 00 is a committed operation.

## Configuration
- USR_ROTATE_EN defined: mode 01 or 10 with rot_i = 1 rotates instead of shifting.
  - Shift up: stage[0] ← old stage[DEPTH-1]; shift down: stage[DEPTH-1] ← old stage[0]. d_i is ignored.
  - cnt is unchanged during a rotate.
  - clr_i and mode 11 keep priority over rotate.
- USR_ROTATE_EN undefined: rot_i is ignored and behaviour is exactly as in Operation.

## Test plan
All scenarios use WIDTH=4, DEPTH=4, RESET_VAL=0.
- Reset: rst_i pulse mid-cycle → q_o=16'h0000, notq_o=16'hFFFF, cnt_o=0, full_o=0 before the next edge.
- Fill by shift up: d_i = 1,2,3,4 on four mode 01 edges → q_o=16'h1234, tail_o=4, head_o=1, cnt_o 1→4, full_o=1.
  - A fifth shift with d_i=5 → q_o=16'h2345, cnt_o stays 4.
- Shift down after load: par_i=16'hABCD with mode 11, then mode 10 with d_i=E → q_o=16'hEABC, cnt_o=4.
- Clear priority: clr_i=1 with mode 11 and par_i=16'hFFFF → q_o=0, cnt_o=0.
  - A hold cycle afterwards leaves q_o unchanged.
- Rotate, with USR_ROTATE_EN: load 16'h1234, then mode 01 with rot_i=1 → q_o=16'h2341, cnt_o=4.
  - Without the macro, the same stimulus with d_i=0 → q_o=16'h2340.
- Reset during streaming: assert rst_i between edges after 2 shifts → q_o=0 immediately.
  - Release on an edge with mode 01: no shift that edge; the next edge loads d_i into tail_o with cnt_o=1.
